// File: rtl/lcd_window_ctrl.sv
// LCD window controller: loads a raster image into on-chip storage and emits a
// rotated / zoomed / shifted WIN x WIN window after every accepted command.
module lcd_window_ctrl #(
  parameter int DW    = 8,
  parameter int IMG_W = 12,
  parameter int IMG_H = 9,
  parameter int WIN   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] datain,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
);

  localparam int N      = IMG_W * IMG_H;
  localparam int NPIX   = WIN * WIN;
  localparam int SX     = IMG_W / WIN;
  localparam int SY     = IMG_H / WIN;
  localparam int X0_MAX = IMG_W - WIN;
  localparam int Y0_MAX = IMG_H - WIN;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned KW = $clog2(NPIX);
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  localparam logic [XW-1:0] X0_C = XW'((IMG_W - WIN) / 2);
  localparam logic [YW-1:0] Y0_C = YW'(IMG_H / 2 - WIN / 2);

  localparam logic [3:0] CMD_LOAD     = 4'd0;
  localparam logic [3:0] CMD_ROT_L    = 4'd1;
  localparam logic [3:0] CMD_ROT_R    = 4'd2;
  localparam logic [3:0] CMD_ZOOM_IN  = 4'd3;
  localparam logic [3:0] CMD_ZOOM_FIT = 4'd4;
  localparam logic [3:0] CMD_SH_R     = 4'd5;
  localparam logic [3:0] CMD_SH_L     = 4'd6;
  localparam logic [3:0] CMD_SH_U     = 4'd7;
  localparam logic [3:0] CMD_SH_D     = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_LOADING, S_EMIT} state_t;

  state_t        state;
  logic [DW-1:0] mem [N];
  logic          zoom;
  logic [1:0]    orient;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [KW-1:0] k;
  logic [AW-1:0] lcnt;

  logic          nx_zoom;
  logic [1:0]    nx_orient;
  logic [XW-1:0] nx_x0;
  logic [YW-1:0] nx_y0;
  logic          shift;
  int            dx, dy, tx, ty;

  logic [KW-1:0] nk;
  int            dr, dc, wr, wc, row, col;
  logic [AW-1:0] addr;
  logic [DW-1:0] rd_data;

  // View state after the command accepted on this edge (current view otherwise).
  always_comb begin
    nx_zoom   = zoom;
    nx_orient = orient;
    nx_x0     = x0;
    nx_y0     = y0;
    shift     = 1'b0;
    dx        = 0;
    dy        = 0;
    tx        = 0;
    ty        = 0;
    if (state == S_IDLE && cmd_valid) begin
      case (cmd)
        CMD_LOAD: begin
          nx_zoom   = 1'b0;
          nx_orient = 2'd0;
          nx_x0     = X0_C;
          nx_y0     = Y0_C;
        end
        CMD_ROT_L:    nx_orient = orient - 2'd1;
        CMD_ROT_R:    nx_orient = orient + 2'd1;
        CMD_ZOOM_IN: begin
          if (!zoom) begin
            nx_zoom = 1'b1;
            nx_x0   = X0_C;
            nx_y0   = Y0_C;
          end
        end
        CMD_ZOOM_FIT: nx_zoom = 1'b0;
        CMD_SH_R, CMD_SH_L: begin
          shift = 1'b1;
          case (orient)
            2'd0:    dx = 1;
            2'd1:    dy = -1;
            2'd2:    dx = -1;
            default: dy = 1;
          endcase
          if (cmd == CMD_SH_L) begin
            dx = -dx;
            dy = -dy;
          end
        end
        CMD_SH_D, CMD_SH_U: begin
          shift = 1'b1;
          case (orient)
            2'd0:    dy = 1;
            2'd1:    dx = 1;
            2'd2:    dy = -1;
            default: dx = -1;
          endcase
          if (cmd == CMD_SH_U) begin
            dx = -dx;
            dy = -dy;
          end
        end
        default: ;
      endcase
      tx = int'(x0) + dx;
      ty = int'(y0) + dy;
      // A step that would leave the image is dropped per axis.
      if (shift && zoom && tx >= 0 && tx <= X0_MAX) nx_x0 = XW'(tx);
      if (shift && zoom && ty >= 0 && ty <= Y0_MAX) nx_y0 = YW'(ty);
    end
  end

  // Source address of the pixel registered on this edge.
  always_comb begin
    nk = (state == S_EMIT) ? k + KW'(1) : '0;
    dr = int'(nk) / WIN;
    dc = int'(nk) % WIN;
    case (nx_orient)
      2'd0:    begin wr = dr;           wc = dc;           end
      2'd1:    begin wr = WIN - 1 - dc; wc = dr;           end
      2'd2:    begin wr = WIN - 1 - dr; wc = WIN - 1 - dc; end
      default: begin wr = dc;           wc = WIN - 1 - dr; end
    endcase
    if (nx_zoom) begin
      row = int'(nx_y0) + wr;
      col = int'(nx_x0) + wc;
    end else begin
      row = wr * SY + SY / 2;
      col = wc * SX + SX / 2;
    end
    addr = AW'(row * IMG_W + col);
  end

  // The first window pixel is read on the edge that writes the last load pixel.
  always_comb rd_data = (state == S_LOADING && addr == lcnt) ? datain : mem[addr];

  always_ff @(posedge clk) begin
    if (!reset && state == S_LOADING) mem[lcnt] <= datain;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      output_valid <= 1'b0;
      dataout      <= '0;
      zoom         <= 1'b0;
      orient       <= 2'd0;
      x0           <= X0_C;
      y0           <= Y0_C;
      k            <= '0;
      lcnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            zoom   <= nx_zoom;
            orient <= nx_orient;
            x0     <= nx_x0;
            y0     <= nx_y0;
            busy   <= 1'b1;
            if (cmd == CMD_LOAD) begin
              state <= S_LOADING;
              lcnt  <= '0;
            end else begin
              state        <= S_EMIT;
              k            <= '0;
              output_valid <= 1'b1;
              dataout      <= rd_data;
            end
          end
        end
        S_LOADING: begin
          lcnt <= lcnt + AW'(1);
          if (lcnt == AW'(N - 1)) begin
            state        <= S_EMIT;
            k            <= '0;
            output_valid <= 1'b1;
            dataout      <= rd_data;
          end
        end
        S_EMIT: begin
          if (k == KW'(NPIX - 1)) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            output_valid <= 1'b0;
          end else begin
            k       <= k + KW'(1);
            dataout <= rd_data;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
